// File: rtl/pdg_pkg.sv
// Shared constants and helpers for parallel_data_gearbox.
// Lane reversal inside each output beat is enabled by defining PDG_LANE_REVERSE_EN.
package pdg_pkg;

    localparam int PDG_SAMPLE_W     = 16;
    localparam int PDG_IN_LANES     = 8;
    // Widest word / sample the lane helper can carry
    localparam int PDG_MAX_WORD_W   = 2048;
    localparam int PDG_MAX_SAMPLE_W = 64;

    function automatic int pdg_ratio(input int in_lanes, input int out_lanes);
        return in_lanes / out_lanes;
    endfunction

    function automatic int pdg_ph_w(input int in_lanes, input int out_lanes);
        int r;
        r = in_lanes / out_lanes;
        return (r <= 1) ? 1 : $clog2(r);
    endfunction

    // Caller truncates the result to its own sample width.
    function automatic logic [PDG_MAX_SAMPLE_W-1:0] lane(input logic [PDG_MAX_WORD_W-1:0] word,
                                                         input int k, input int sample_w);
        return PDG_MAX_SAMPLE_W'(word >> (k * sample_w));
    endfunction

endpackage

// File: rtl/pdg_slice_mux.sv
// Combinational slice selector: picks the OUT_LANES samples of word at slot phase.
// PDG_LANE_REVERSE_EN reverses lane order within the beat.
module pdg_slice_mux
    import pdg_pkg::*;
#(
    parameter int SAMPLE_W  = PDG_SAMPLE_W,
    parameter int IN_LANES  = PDG_IN_LANES,
    parameter int OUT_LANES = 2,
    parameter int PH_W      = 2
) (
    input  logic [IN_LANES*SAMPLE_W-1:0]  word,
    input  logic [PH_W-1:0]               phase,
    output logic [OUT_LANES*SAMPLE_W-1:0] beat
);

    logic [PDG_MAX_WORD_W-1:0]          word_ext;
    logic [OUT_LANES-1:0][SAMPLE_W-1:0] lanes;

    assign word_ext = PDG_MAX_WORD_W'(word);

    for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
`ifdef PDG_LANE_REVERSE_EN
        localparam int SRC = OUT_LANES - 1 - j;
`else
        localparam int SRC = j;
`endif
        assign lanes[j] = SAMPLE_W'(lane(word_ext, int'(phase) * OUT_LANES + SRC, SAMPLE_W));
    end

    assign beat = lanes;

endmodule

// File: rtl/parallel_data_gearbox.sv
// Width-reducing gearbox: one IN_LANES word in, RATIO beats of OUT_LANES samples out.
// Optional PDG_LANE_REVERSE_EN reverses lanes within each beat (see pdg_slice_mux).
module parallel_data_gearbox
    import pdg_pkg::*;
#(
    parameter int SAMPLE_W  = PDG_SAMPLE_W,
    parameter int IN_LANES  = PDG_IN_LANES,
    parameter int OUT_LANES = 2,
    localparam int RATIO    = pdg_ratio(IN_LANES, OUT_LANES),
    localparam int PH_W     = pdg_ph_w(IN_LANES, OUT_LANES)
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [IN_LANES*SAMPLE_W-1:0]  s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [OUT_LANES*SAMPLE_W-1:0] m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [PH_W-1:0]               m_phase,
    output logic                          m_last
);

    if (OUT_LANES < 1 || IN_LANES % OUT_LANES != 0) begin : g_bad_lanes
        $error("parallel_data_gearbox: OUT_LANES must divide IN_LANES");
    end
    if (IN_LANES * SAMPLE_W > PDG_MAX_WORD_W || SAMPLE_W > PDG_MAX_SAMPLE_W) begin : g_bad_width
        $error("parallel_data_gearbox: word or sample too wide for pdg_pkg::lane");
    end

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(RATIO - 1);

    logic [IN_LANES*SAMPLE_W-1:0] word_q;
    logic                         busy_q;
    logic [PH_W-1:0]              phase_q;
    logic                         at_last;
    logic                         accept;

    assign at_last = (phase_q == LAST_PH);
    // Last beat leaving frees the holding register in the same cycle
    assign s_ready = !busy_q || (m_ready && at_last);
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            word_q  <= '0;
            busy_q  <= 1'b0;
            phase_q <= '0;
        end else if (accept) begin
            word_q  <= s_data;
            busy_q  <= 1'b1;
            phase_q <= '0;
        end else if (busy_q && m_ready) begin
            if (at_last) begin
                busy_q  <= 1'b0;
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + 1'b1;
            end
        end
    end

    pdg_slice_mux #(
        .SAMPLE_W (SAMPLE_W),
        .IN_LANES (IN_LANES),
        .OUT_LANES(OUT_LANES),
        .PH_W     (PH_W)
    ) u_mux (
        .word (word_q),
        .phase(phase_q),
        .beat (m_data)
    );

    assign m_valid = busy_q;
    assign m_phase = phase_q;
    assign m_last  = at_last;

endmodule

// File: tb/tb_parallel_data_gearbox.sv
// Directed bench: default 8->2 gearbox plus an 8->8 (RATIO 1) instance.
// Expected beats follow PDG_LANE_REVERSE_EN when it is defined.
module tb_parallel_data_gearbox;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    // 8 -> 2 lanes
    logic [127:0] a_s_data;
    logic         a_s_valid, a_s_ready;
    logic [31:0]  a_m_data;
    logic         a_m_valid, a_m_ready;
    logic [1:0]   a_m_phase;
    logic         a_m_last;

    // 8 -> 8 lanes
    logic [127:0] b_s_data;
    logic         b_s_valid, b_s_ready;
    logic [127:0] b_m_data;
    logic         b_m_valid, b_m_ready;
    logic [0:0]   b_m_phase;
    logic         b_m_last;

    parallel_data_gearbox #(.SAMPLE_W(16), .IN_LANES(8), .OUT_LANES(2)) u_dut_a (
        .clock(clock), .resetn(resetn),
        .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
        .m_phase(a_m_phase), .m_last(a_m_last));

    parallel_data_gearbox #(.SAMPLE_W(16), .IN_LANES(8), .OUT_LANES(8)) u_dut_b (
        .clock(clock), .resetn(resetn),
        .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_phase(b_m_phase), .m_last(b_m_last));

    localparam logic [127:0] W0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    localparam logic [127:0] W1 = 128'h000F_000E_000D_000C_000B_000A_0009_0008;
    localparam logic [127:0] WA = 128'h0017_0016_0015_0014_0013_0012_0011_0010;
    localparam logic [127:0] WB = 128'h0027_0026_0025_0024_0023_0022_0021_0020;
`ifdef PDG_LANE_REVERSE_EN
    localparam logic [31:0] EXP [8] = '{32'h0000_0001, 32'h0002_0003, 32'h0004_0005, 32'h0006_0007,
                                        32'h0008_0009, 32'h000A_000B, 32'h000C_000D, 32'h000E_000F};
    localparam logic [31:0] EXP_B0 = 32'h0020_0021;
`else
    localparam logic [31:0] EXP [8] = '{32'h0001_0000, 32'h0003_0002, 32'h0005_0004, 32'h0007_0006,
                                        32'h0009_0008, 32'h000B_000A, 32'h000D_000C, 32'h000F_000E};
    localparam logic [31:0] EXP_B0 = 32'h0021_0020;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked 1 unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [127:0] sb_q [$];
    logic         b_acc, b_acc_prev;
    logic [127:0] b_last_word;

    initial begin
        resetn    = 1'b0;
        a_s_valid = 1'b1; a_s_data = W0; a_m_ready = 1'b1;
        b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b1;

        // Reset held with a valid word offered
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("rst_m_valid", 128'(a_m_valid), 128'd0);
            chk("rst_m_phase", 128'(a_m_phase), 128'd0);
            chk("rst_m_data",  128'(a_m_data),  128'd0);
        end
        step();
        resetn = 1'b1;
        #1;
        chk("rel_s_ready", 128'(a_s_ready), 128'd1);

        // Streaming: W0 then W1 back to back
        step();
        a_s_data = W1;
        for (int b = 0; b < 8; b++) begin
            if (b > 0) step();
            if (b == 4) a_s_valid = 1'b0;
            #1;
            chk("str_m_valid", 128'(a_m_valid), 128'd1);
            chk("str_m_data",  128'(a_m_data),  128'(EXP[b]));
            chk("str_m_phase", 128'(a_m_phase), 128'(b % 4));
            chk("str_m_last",  128'(a_m_last),  128'(b % 4 == 3));
            chk("str_s_ready", 128'(a_s_ready), 128'(b % 4 == 3));
        end
        step(); #1;
        chk("str_idle", 128'(a_m_valid), 128'd0);

        // Backpressure at phase 2
        a_s_valid = 1'b1; a_s_data = W0;
        step();
        a_s_valid = 1'b0;
        step();
        step();
        a_m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_m_data",  128'(a_m_data),  128'(EXP[2]));
            chk("bp_m_phase", 128'(a_m_phase), 128'd2);
            chk("bp_s_ready", 128'(a_s_ready), 128'd0);
            step();
        end
        a_m_ready = 1'b1;
        #1;
        chk("bp_resume2", 128'(a_m_data), 128'(EXP[2]));
        step(); #1;
        chk("bp_ph3_data", 128'(a_m_data), 128'(EXP[3]));
        chk("bp_ph3_last", 128'(a_m_last), 128'd1);
        step(); #1;
        chk("bp_done", 128'(a_m_valid), 128'd0);

        // Mid-word reset at phase 1 of WA
        a_s_valid = 1'b1; a_s_data = WA;
        step();
        a_s_valid = 1'b0;
        step(); #1;
        chk("mw_phase1", 128'(a_m_phase), 128'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        chk("mw_cleared", 128'(a_m_valid), 128'd0);
        a_s_valid = 1'b1; a_s_data = WB;
        step();
        a_s_valid = 1'b0;
        #1;
        chk("mw_first_valid", 128'(a_m_valid), 128'd1);
        chk("mw_first_data",  128'(a_m_data),  128'(EXP_B0));
        chk("mw_first_phase", 128'(a_m_phase), 128'd0);
        repeat (4) step();

        // RATIO 1 instance with random valid/ready
        b_acc_prev = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (!b_s_valid || b_acc_prev) begin
                b_s_valid = 1'($urandom_range(0, 1));
                b_s_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            b_m_ready = 1'($urandom_range(0, 3) != 0);
            #1;
            if (b_acc_prev) begin
                chk("r1_latency_valid", 128'(b_m_valid), 128'd1);
                chk("r1_latency_data",  b_m_data, b_last_word);
            end
            if (b_m_valid && b_m_ready) begin
                if (sb_q.size() == 0) chk("r1_unexpected_beat", 128'(b_m_valid), 128'd0);
                else chk("r1_data", b_m_data, sb_q.pop_front());
                chk("r1_last",  128'(b_m_last),  128'd1);
                chk("r1_phase", 128'(b_m_phase), 128'd0);
            end
            b_acc = b_s_valid && b_s_ready;
            if (b_acc) begin
                sb_q.push_back(b_s_data);
                b_last_word = b_s_data;
            end
            b_acc_prev = b_acc;
            step();
        end
        b_s_valid = 1'b0;
        b_m_ready = 1'b1;
        #1;
        if (b_m_valid) begin
            if (sb_q.size() == 0) chk("r1_unexpected_beat", 128'(b_m_valid), 128'd0);
            else chk("r1_drain", b_m_data, sb_q.pop_front());
        end
        step();
        chk("r1_queue_empty", 128'(sb_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/parallel_data_gearbox.md
# parallel_data_gearbox

Parametrised width-reducing gearbox for multi-sample RFSoC data words. It accepts one word of IN_LANES samples per input handshake and emits it as RATIO = IN_LANES/OUT_LANES consecutive output beats of OUT_LANES samples each, lane 0 first. Both sides use valid/ready handshakes. It sits between the wide converter-side sample stream (8×16-bit at fabric rate) and narrower downstream DSP or capture logic, and generalises the fixed 8-lane 16-bit slicer.

## Interface
- SAMPLE_W, 16, bits per sample.
- IN_LANES, 8, samples per input word.
- OUT_LANES, 2, samples per output beat; must divide IN_LANES; elaboration error otherwise.
- PH_W, derived = max(1, clog2(IN_LANES/OUT_LANES)); not user-set.
- clock  in  1  sole clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- s_data  in  IN_LANES*SAMPLE_W  input word; lane k occupies bits [SAMPLE_W*(k+1)-1 : SAMPLE_W*k].
- s_valid  in  1  input word valid.
- s_ready  out  1  block can take a word this cycle.
- m_data  out  OUT_LANES*SAMPLE_W  output beat; same lane packing as s_data.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts beat.
- m_phase  out  PH_W  index of the current slice within the held word, 0..RATIO-1.
- m_last  out  1  high when m_phase == RATIO-1.

## Operation
- State: word_q (held input word), busy_q (equals m_valid), phase_q.
- s_ready = !busy_q || (m_ready && phase_q == RATIO-1). Combinational on m_ready; no combinational path from s_valid.
- Input accept (s_valid && s_ready): word_q <= s_data, busy_q <= 1, phase_q <= 0.
- Output transfer (m_valid && m_ready) with no accept: if phase_q == RATIO-1, busy_q <= 0 and phase_q <= 0; otherwise phase_q <= phase_q + 1.
- A simultaneous last-beat transfer and new accept takes the accept path, giving gap-free back-to-back words.
- m_data = lanes [OUT_LANES*phase_q .. OUT_LANES*(phase_q+1)-1] of word_q. This is a mux of registered state only.
- m_valid low: m_data still shows the word_q slice. It is don't-care downstream.
- m_valid high and m_ready low: m_data, m_phase and m_last hold stable. No beat is ever dropped or duplicated.
- RATIO == 1: acts as a single-register pipeline stage. m_phase is always 0, m_last is always 1.
- The block never drops input. Backpressure propagates only through s_ready.

## Timing
- Reset values (resetn low at a rising edge): word_q = 0, busy_q = 0, phase_q = 0, so m_valid = 0, m_phase = 0 and m_data = 0. s_ready = 1 from the first cycle after reset.
- Reset mid-word discards the held word and any remaining slices. The first post-reset beat comes from the next accepted word.
- Latency: a word accepted at edge N gives slice 0 valid in the cycle after edge N. Slice j appears no earlier than j cycles later.
- Sustained throughput with m_ready held high: 1 output beat per cycle, 1 input word per RATIO cycles.
- s_ready may deassert for RATIO-1 cycles per word. Upstream holds s_data and s_valid until accepted.

## Configuration
- PDG_LANE_REVERSE_EN defined: lanes within each output beat are emitted in reversed order (beat lane 0 = highest lane of the slice). Slice order across beats is unchanged.
- PDG_LANE_REVERSE_EN undefined: natural lane order as described above.

## Structure
- Shared package pdg_pkg holds:
  - lane-extract function lane(word, k, SAMPLE_W);
  - PH_W and RATIO computation functions;
  - the default parameter constants PDG_SAMPLE_W = 16 and PDG_IN_LANES = 8.
- One natural sub-module: pdg_slice_mux. It is purely combinational, maps word_q and phase_q to m_data, and contains the lane-reverse option.
- The handshake, phase counter and holding register stay in the top module.

## Test plan
- Reset: assert resetn = 0 for 3 cycles with s_valid = 1 -> m_valid = 0, m_phase = 0 and m_data = 0 during reset; s_ready = 1 on the first cycle after release.
- Streaming, default params, m_ready = 1: input words 0x0007_0006_..._0000 then 0x000F_..._0008 -> 8 consecutive beats 0x0001_0000, 0x0003_0002, …, 0x000F_000E. m_last high on beats 4 and 8. s_ready high on each last-beat cycle and no idle gap between words.
- Backpressure: hold m_ready = 0 for 5 cycles at phase 2 -> m_data stays 0x0005_0004, m_phase stays 2, s_ready stays 0. Resume -> phases 3, 0 continue with no loss.
- Mid-word reset: reset at phase 1 of word A, then send word B -> first beat after reset is B's lanes 1:0. No A data appears.
- OUT_LANES = 8 (RATIO = 1), random valid/ready -> output sequence equals input sequence, m_last always 1, one cycle latency.
- PDG_LANE_REVERSE_EN defined, default params, word with lane k = k -> beats 0x0000_0001, 0x0002_0003, 0x0004_0005, 0x0006_0007.
